// File: rtl/mips_id_ctl_stage.sv
// rtl/mips_id_ctl_stage.sv - MIPS decode control, ID/EX control register, load-use/JR hazard stall, stall counter
// Optional immediate-logic opcodes (ANDI/ORI/XORI/SLTI) enabled by defining MIPS_IMM_LOGIC_EN.
module mips_id_ctl_stage #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            instr_d,
  input  logic                   valid_d,
  input  logic                   flush_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   jump_d,
  output logic                   jr_d,
  output logic                   jal_d,
  output logic                   regwrite_e,
  output logic                   memtoreg_e,
  output logic                   memwrite_e,
  output logic                   alusrc_e,
  output logic                   branch_e,
  output logic                   bne_e,
  output logic [1:0]             regdst_e,
  output logic [2:0]             alucontrol_e,
  output logic [4:0]             rs_e,
  output logic [4:0]             rt_e,
  output logic [4:0]             rd_e,
  output logic [DATA_W-1:0]      imm_e,
  output logic                   valid_e,
  output logic                   illegal_e,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;
`ifdef MIPS_IMM_LOGIC_EN
  localparam logic [5:0] OP_SLTI   = 6'd10;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
`endif

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  logic [5:0] opcode, funct;
  logic [4:0] rs_d, rt_d, rd_d;

  assign opcode = instr_d[31:26];
  assign funct  = instr_d[5:0];
  assign rs_d   = instr_d[25:21];
  assign rt_d   = instr_d[20:16];
  assign rd_d   = instr_d[15:11];

  logic       dec_regwrite, dec_memtoreg, dec_memwrite, dec_alusrc;
  logic       dec_branch, dec_bne, dec_jump, dec_jr, dec_jal;
  logic       dec_illegal, dec_reads_rt, dec_zext;
  logic [1:0] dec_regdst;
  logic [2:0] dec_alu;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_bne      = 1'b0;
    dec_jump     = 1'b0;
    dec_jr       = 1'b0;
    dec_jal      = 1'b0;
    dec_illegal  = 1'b0;
    dec_reads_rt = 1'b0;
    dec_zext     = 1'b0;
    dec_regdst   = RD_RT;
    dec_alu      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_regdst   = RD_RD;
        dec_reads_rt = 1'b1;
        case (funct)
          F_ADD: dec_alu = ALU_ADD;
          F_SUB: dec_alu = ALU_SUB;
          F_AND: dec_alu = ALU_AND;
          F_OR:  dec_alu = ALU_OR;
          F_XOR: dec_alu = ALU_XOR;
          F_NOR: dec_alu = ALU_NOR;
          F_SLT: dec_alu = ALU_SLT;
          F_JR: begin
            dec_regwrite = 1'b0;
            dec_regdst   = RD_RT;
            dec_reads_rt = 1'b0;
            dec_jr       = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      OP_LW: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
      end
      OP_SW: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_reads_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_branch   = 1'b1;
        dec_bne      = (opcode == OP_BNE);
        dec_alu      = ALU_SUB;
        dec_reads_rt = 1'b1;
      end
      // BLTZ/BGEZ share the opcode; rt[0] is consumed by the branch comparator in EX
      OP_REGIMM: begin
        dec_branch = 1'b1;
        dec_alu    = ALU_SLT;
      end
      OP_J: dec_jump = 1'b1;
      OP_JAL: begin
        dec_jal      = 1'b1;
        dec_regwrite = 1'b1;
        dec_regdst   = RD_RA;
      end
`ifdef MIPS_IMM_LOGIC_EN
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_zext     = 1'b1;
        dec_alu      = (opcode == OP_ANDI) ? ALU_AND :
                       (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_SLTI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_SLT;
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_regwrite = 1'b0;
      dec_memtoreg = 1'b0;
      dec_memwrite = 1'b0;
      dec_alusrc   = 1'b0;
      dec_branch   = 1'b0;
      dec_bne      = 1'b0;
      dec_jump     = 1'b0;
      dec_jr       = 1'b0;
      dec_jal      = 1'b0;
      dec_reads_rt = 1'b0;
      dec_zext     = 1'b0;
      dec_regdst   = RD_RT;
      dec_alu      = ALU_AND;
    end
  end

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = dec_zext ? {{(DATA_W-16){1'b0}}, instr_d[15:0]}
                            : {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};

  assign jump_d = valid_d & dec_jump;
  assign jr_d   = valid_d & dec_jr;
  assign jal_d  = valid_d & dec_jal;

  logic [4:0] dest_e;
  always_comb begin
    dest_e = rt_e;
    case (regdst_e)
      RD_RD:   dest_e = rd_e;
      RD_RA:   dest_e = 5'd31;
      default: dest_e = rt_e;
    endcase
  end

  logic load_use, jr_hazard;
  assign load_use  = valid_e & memtoreg_e & (rt_e != 5'd0) & valid_d &
                     ((rt_e == rs_d) | (dec_reads_rt & (rt_e == rt_d)));
  // JR resolves in decode, so it must wait for any in-flight write to its source
  assign jr_hazard = jr_d & valid_e & regwrite_e & (dest_e != 5'd0) & (dest_e == rs_d);

  assign stall_d = load_use | jr_hazard;
  assign stall_f = stall_d;

  logic bubble;
  assign bubble = flush_e | stall_d | ~valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_e   <= 1'b0;
      memtoreg_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      bne_e        <= 1'b0;
      regdst_e     <= 2'b00;
      alucontrol_e <= 3'b000;
      rs_e         <= 5'd0;
      rt_e         <= 5'd0;
      rd_e         <= 5'd0;
      imm_e        <= '0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (bubble) begin
      regwrite_e   <= 1'b0;
      memtoreg_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      bne_e        <= 1'b0;
      regdst_e     <= 2'b00;
      alucontrol_e <= 3'b000;
      rs_e         <= 5'd0;
      rt_e         <= 5'd0;
      rd_e         <= 5'd0;
      imm_e        <= '0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else begin
      regwrite_e   <= dec_regwrite;
      memtoreg_e   <= dec_memtoreg;
      memwrite_e   <= dec_memwrite;
      alusrc_e     <= dec_alusrc;
      branch_e     <= dec_branch;
      bne_e        <= dec_bne;
      regdst_e     <= dec_regdst;
      alucontrol_e <= dec_alu;
      rs_e         <= rs_d;
      rt_e         <= rt_d;
      rd_e         <= rd_d;
      imm_e        <= imm_ext;
      valid_e      <= 1'b1;
      illegal_e    <= dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall_d && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mips_id_ctl_stage.sv
// tb/tb_mips_id_ctl_stage.sv - self-checking bench for mips_id_ctl_stage (vector table, corner sequences, random vs model)
module tb_mips_id_ctl_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] instr_d;
  logic        valid_d, flush_e;

  logic        stall_f, stall_d, jump_d, jr_d, jal_d;
  logic        regwrite_e, memtoreg_e, memwrite_e, alusrc_e, branch_e, bne_e;
  logic [1:0]  regdst_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [31:0] imm_e;
  logic        valid_e, illegal_e;
  logic [15:0] stall_count;

  logic        s_stall_f, s_stall_d, s_jump_d, s_jr_d, s_jal_d;
  logic        s_regwrite_e, s_memtoreg_e, s_memwrite_e, s_alusrc_e, s_branch_e, s_bne_e;
  logic [1:0]  s_regdst_e;
  logic [2:0]  s_alucontrol_e;
  logic [4:0]  s_rs_e, s_rt_e, s_rd_e;
  logic [31:0] s_imm_e;
  logic        s_valid_e, s_illegal_e;
  logic [1:0]  stall_count_s;

  mips_id_ctl_stage #(.DATA_W(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .valid_d(valid_d), .flush_e(flush_e),
    .stall_f(stall_f), .stall_d(stall_d), .jump_d(jump_d), .jr_d(jr_d), .jal_d(jal_d),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .alusrc_e(alusrc_e), .branch_e(branch_e), .bne_e(bne_e), .regdst_e(regdst_e),
    .alucontrol_e(alucontrol_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .imm_e(imm_e),
    .valid_e(valid_e), .illegal_e(illegal_e), .stall_count(stall_count)
  );

  mips_id_ctl_stage #(.DATA_W(32), .STALL_CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .valid_d(valid_d), .flush_e(flush_e),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .jump_d(s_jump_d), .jr_d(s_jr_d), .jal_d(s_jal_d),
    .regwrite_e(s_regwrite_e), .memtoreg_e(s_memtoreg_e), .memwrite_e(s_memwrite_e),
    .alusrc_e(s_alusrc_e), .branch_e(s_branch_e), .bne_e(s_bne_e), .regdst_e(s_regdst_e),
    .alucontrol_e(s_alucontrol_e), .rs_e(s_rs_e), .rt_e(s_rt_e), .rd_e(s_rd_e), .imm_e(s_imm_e),
    .valid_e(s_valid_e), .illegal_e(s_illegal_e), .stall_count(stall_count_s)
  );

  typedef struct packed {
    logic        valid, illegal, regwrite, memtoreg, memwrite, alusrc, branch, bne;
    logic [1:0]  regdst;
    logic [2:0]  alu;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
  } ex_t;

  typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_JR, M_ADDI, M_LW,
                M_SW, M_BEQ, M_BNE, M_BZ, M_J, M_JAL, M_ANDI, M_ORI, M_XORI, M_SLTI} mn_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid, flush, stall;
    logic [2:0]  redir;
    logic [7:0]  ctl;
    logic [1:0]  regdst;
    logic [2:0]  alu;
    logic [31:0] imm;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  ex_t  ref_ex;
  int   ref_cnt, ref_cnt_s;
  logic s_stall;
  logic [2:0] s_redir;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic mn_t classify(input logic [31:0] ins);
    case (ins[31:26])
      6'd0: case (ins[5:0])
        6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
        6'h25: return M_OR;   6'h26: return M_XOR;  6'h27: return M_NOR;
        6'h2A: return M_SLT;  6'h08: return M_JR;
        default: return M_ILL;
      endcase
      6'd8:  return M_ADDI;
      6'd35: return M_LW;
      6'd43: return M_SW;
      6'd4:  return M_BEQ;
      6'd5:  return M_BNE;
      6'd1:  return M_BZ;
      6'd2:  return M_J;
      6'd3:  return M_JAL;
`ifdef MIPS_IMM_LOGIC_EN
      6'd12: return M_ANDI;
      6'd13: return M_ORI;
      6'd14: return M_XORI;
      6'd10: return M_SLTI;
`endif
      default: return M_ILL;
    endcase
  endfunction

  // Expected EX contents per mnemonic; rrt = reads rt, rdr = {jump, jr, jal}
  function automatic ex_t ref_decode(input logic [31:0] ins, output logic rrt, output logic [2:0] rdr);
    ex_t e;
    mn_t m;
    m = classify(ins);
    e = '0;
    e.valid = 1'b1;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.alu = 3'b010;
    rrt = 1'b0;
    rdr = 3'b000;
    case (m)
      M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT: begin
        e.regwrite = 1'b1; e.regdst = 2'b01; rrt = 1'b1;
        e.alu = (m == M_ADD) ? 3'b010 : (m == M_SUB) ? 3'b110 : (m == M_AND) ? 3'b000 :
                (m == M_OR)  ? 3'b001 : (m == M_XOR) ? 3'b011 : (m == M_NOR) ? 3'b100 : 3'b111;
      end
      M_JR:   rdr = 3'b010;
      M_ADDI: begin e.regwrite = 1'b1; e.alusrc = 1'b1; end
      M_LW:   begin e.regwrite = 1'b1; e.alusrc = 1'b1; e.memtoreg = 1'b1; end
      M_SW:   begin e.memwrite = 1'b1; e.alusrc = 1'b1; rrt = 1'b1; end
      M_BEQ:  begin e.branch = 1'b1; e.alu = 3'b110; rrt = 1'b1; end
      M_BNE:  begin e.branch = 1'b1; e.bne = 1'b1; e.alu = 3'b110; rrt = 1'b1; end
      M_BZ:   begin e.branch = 1'b1; e.alu = 3'b111; end
      M_J:    rdr = 3'b100;
      M_JAL:  begin rdr = 3'b001; e.regwrite = 1'b1; e.regdst = 2'b10; end
      M_ANDI, M_ORI, M_XORI: begin
        e.regwrite = 1'b1; e.alusrc = 1'b1; e.imm = {16'd0, ins[15:0]};
        e.alu = (m == M_ANDI) ? 3'b000 : (m == M_ORI) ? 3'b001 : 3'b011;
      end
      M_SLTI: begin e.regwrite = 1'b1; e.alusrc = 1'b1; e.alu = 3'b111; end
      default: begin e.illegal = 1'b1; e.alu = 3'b000; end
    endcase
    return e;
  endfunction

  function automatic logic ref_stall(input logic [31:0] ins, input logic v, input logic rrt, input logic is_jr);
    logic [4:0] dest;
    logic lu, jh;
    dest = (ref_ex.regdst == 2'b01) ? ref_ex.rd : (ref_ex.regdst == 2'b10) ? 5'd31 : ref_ex.rt;
    lu = ref_ex.valid && ref_ex.memtoreg && ref_ex.rt != 0 && v &&
         (ref_ex.rt == ins[25:21] || (rrt && ref_ex.rt == ins[20:16]));
    jh = is_jr && ref_ex.valid && ref_ex.regwrite && dest != 0 && dest == ins[25:21];
    return lu || jh;
  endfunction

  function automatic ex_t dut_ex();
    return {valid_e, illegal_e, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, branch_e, bne_e,
            regdst_e, alucontrol_e, rs_e, rt_e, rd_e, imm_e};
  endfunction

  // Entered and left at posedge+1; combinational checks at the falling edge
  task automatic step(input logic [31:0] ins, input logic v, input logic f);
    logic rrt, exp_stall;
    logic [2:0] rdr;
    ex_t d;
    instr_d = ins; valid_d = v; flush_e = f;
    d = ref_decode(ins, rrt, rdr);
    if (!v) rdr = 3'b000;
    exp_stall = ref_stall(ins, v, rrt, rdr[1]);
    @(negedge clk);
    s_stall = stall_d;
    s_redir = {jump_d, jr_d, jal_d};
    chk("stall", 64'({stall_f, stall_d}), 64'({exp_stall, exp_stall}));
    chk("redirect", 64'(s_redir), 64'(rdr));
    @(posedge clk); #1;
    ref_ex = (f || exp_stall || !v) ? '0 : d;
    if (exp_stall) begin
      if (ref_cnt < 65535) ref_cnt++;
      if (ref_cnt_s < 3) ref_cnt_s++;
    end
    chk("ex_regs", 64'(dut_ex()), 64'(ref_ex));
    chk("stall_count", 64'(stall_count), 64'(ref_cnt));
    chk("stall_count_w2", 64'(stall_count_s), 64'(ref_cnt_s));
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [15:0] im;
    logic [5:0] fn;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    im = 16'($urandom);
    case ($urandom_range(0, 13))
      0: begin
        case ($urandom_range(0, 7))
          0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
          4: fn = 6'h26; 5: fn = 6'h27; 6: fn = 6'h2A; default: fn = 6'h01;
        endcase
        return enc_r(a, b, c, fn);
      end
      1: return enc_r(a, 5'd0, 5'd0, 6'h08);
      2: return enc_i(6'd8, a, b, im);
      3, 4: return enc_i(6'd35, a, b, im);
      5: return enc_i(6'd43, a, b, im);
      6: return enc_i(6'd4, a, b, im);
      7: return enc_i(6'd5, a, b, im);
      8: return enc_i(6'd1, a, 5'($urandom_range(0, 1)), im);
      9: return {6'd2, 26'($urandom)};
      10: return {6'd3, 26'($urandom)};
      11: return enc_i(6'($urandom_range(10, 14)), a, b, im);
      12: return {6'd63, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  function automatic vec_t mkv(input logic [31:0] i, input logic v, input logic f, input logic s,
                               input logic [2:0] r, input logic [7:0] c, input logic [1:0] rd,
                               input logic [2:0] a, input logic [31:0] im);
    vec_t x;
    x.instr = i; x.valid = v; x.flush = f; x.stall = s; x.redir = r;
    x.ctl = c; x.regdst = rd; x.alu = a; x.imm = im;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    logic [31:0] ins_lw, ins_add;
    logic rrt;
    logic [2:0] rdr;

    ins_add = enc_r(5'd8, 5'd10, 5'd9, 6'h20);
    // ctl = {valid, illegal, regwrite, memtoreg, memwrite, alusrc, branch, bne}
    vecs[0]  = mkv(enc_i(6'd35, 5'd16, 5'd8, 16'h0004), 1, 0, 0, 3'b000, 8'b1011_0100, 2'b00, 3'b010, 32'h4);
    vecs[1]  = mkv(ins_add, 1, 0, 1, 3'b000, 8'h00, 2'b00, 3'b000, 32'h0);
    vecs[2]  = mkv(ins_add, 1, 0, 0, 3'b000, 8'b1010_0000, 2'b01, 3'b010, 32'h4820);
    vecs[3]  = mkv(enc_i(6'd35, 5'd8, 5'd0, 16'h0), 1, 0, 0, 3'b000, 8'b1011_0100, 2'b00, 3'b010, 32'h0);
    vecs[4]  = mkv(enc_r(5'd0, 5'd0, 5'd9, 6'h20), 1, 0, 0, 3'b000, 8'b1010_0000, 2'b01, 3'b010, 32'h4820);
    vecs[5]  = mkv(enc_i(6'd35, 5'd16, 5'd8, 16'h0), 1, 0, 0, 3'b000, 8'b1011_0100, 2'b00, 3'b010, 32'h0);
    vecs[6]  = mkv(enc_i(6'd43, 5'd8, 5'd9, 16'h0), 1, 0, 1, 3'b000, 8'h00, 2'b00, 3'b000, 32'h0);
    vecs[7]  = mkv(enc_i(6'd43, 5'd8, 5'd9, 16'h0), 1, 0, 0, 3'b000, 8'b1000_1100, 2'b00, 3'b010, 32'h0);
    vecs[8]  = mkv(enc_i(6'd4, 5'd9, 5'd10, 16'hFFFF), 1, 0, 0, 3'b000, 8'b1000_0010, 2'b00, 3'b110, 32'hFFFF_FFFF);
    vecs[9]  = mkv(enc_i(6'd8, 5'd9, 5'd8, 16'hFFFF), 1, 1, 0, 3'b000, 8'h00, 2'b00, 3'b000, 32'h0);
    vecs[10] = mkv(enc_i(6'd8, 5'd9, 5'd8, 16'hFFFF), 1, 0, 0, 3'b000, 8'b1010_0100, 2'b00, 3'b010, 32'hFFFF_FFFF);
    vecs[11] = mkv(32'hFC00_0000, 1, 0, 0, 3'b000, 8'b1100_0000, 2'b00, 3'b000, 32'h0);
`ifdef MIPS_IMM_LOGIC_EN
    vecs[12] = mkv(enc_i(6'd13, 5'd9, 5'd8, 16'h8000), 1, 0, 0, 3'b000, 8'b1010_0100, 2'b00, 3'b001, 32'h0000_8000);
`else
    vecs[12] = mkv(enc_i(6'd13, 5'd9, 5'd8, 16'h8000), 1, 0, 0, 3'b000, 8'b1100_0000, 2'b00, 3'b000, 32'hFFFF_8000);
`endif
    vecs[13] = mkv({6'd3, 26'h10}, 1, 0, 0, 3'b001, 8'b1010_0000, 2'b10, 3'b010, 32'h10);
    vecs[14] = mkv(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 1, 0, 1, 3'b010, 8'h00, 2'b00, 3'b000, 32'h0);
    vecs[15] = mkv(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 1, 0, 0, 3'b010, 8'b1000_0000, 2'b00, 3'b010, 32'h8);
    vecs[16] = mkv({6'd2, 26'h10}, 0, 0, 0, 3'b000, 8'h00, 2'b00, 3'b000, 32'h0);

    reset_n = 1'b0; instr_d = '0; valid_d = 1'b0; flush_e = 1'b0;
    ref_ex = '0; ref_cnt = 0; ref_cnt_s = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex", 64'(dut_ex()), 64'd0);
    chk("reset_cnt", 64'(stall_count), 64'd0);
    chk("reset_stall", 64'(stall_d), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].instr, vecs[i].valid, vecs[i].flush);
      chk($sformatf("vec%0d_stall", i), 64'(s_stall), 64'(vecs[i].stall));
      chk($sformatf("vec%0d_redir", i), 64'(s_redir), 64'(vecs[i].redir));
      chk($sformatf("vec%0d_ctl", i), 64'({valid_e, illegal_e, regwrite_e, memtoreg_e, memwrite_e,
                                            alusrc_e, branch_e, bne_e}), 64'(vecs[i].ctl));
      chk($sformatf("vec%0d_regdst_alu", i), 64'({regdst_e, alucontrol_e}), 64'({vecs[i].regdst, vecs[i].alu}));
      chk($sformatf("vec%0d_imm", i), 64'(imm_e), 64'(vecs[i].imm));
    end
    chk("table_stall_count", 64'(stall_count), 64'd3);

    // asynchronous reset with a load sitting in EX and a dependent op in decode
    ins_lw = enc_i(6'd35, 5'd16, 5'd8, 16'h0);
    step(ins_lw, 1, 0);
    instr_d = ins_add; valid_d = 1'b1; flush_e = 1'b0;
    #2;
    chk("pre_reset_stall", 64'(stall_d), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_ex", 64'(dut_ex()), 64'd0);
    chk("async_reset_cnt", 64'(stall_count), 64'd0);
    chk("async_reset_stall", 64'(stall_d), 64'd0);
    ref_ex = '0; ref_cnt = 0; ref_cnt_s = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    ref_ex = ref_decode(ins_add, rrt, rdr);
    chk("post_reset_ex", 64'(dut_ex()), 64'(ref_ex));
    chk("post_reset_cnt", 64'(stall_count), 64'd0);

    // flush and stall in the same cycle: one bubble, counter still advances
    step(ins_lw, 1, 0);
    step(ins_add, 1, 1);
    chk("flush_stall_flag", 64'(s_stall), 64'd1);
    chk("flush_stall_bubble", 64'(valid_e), 64'd0);
    chk("flush_stall_cnt", 64'(stall_count), 64'd1);
    step(ins_add, 1, 0);
    chk("after_flush_stall_valid", 64'(valid_e), 64'd1);

    for (int k = 0; k < 5; k++) begin
      step(ins_lw, 1, 0);
      step(ins_add, 1, 0);
      step(ins_add, 1, 0);
    end
    chk("narrow_cnt_saturated", 64'(stall_count_s), 64'd3);
    chk("wide_cnt_after_six", 64'(stall_count), 64'd6);

    for (int k = 0; k < 400; k++) begin
      step(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
